viterbi_codec: RTL and testbench
================================

Name: viterbi_codec

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder and matching hard-decision Viterbi decoder in one block.
- Decoder uses register-exchange survivors.
- The two halves share only the clock and reset. The integrating top level routes the encoder symbols, with optional error injection and a one-cycle register, into the decoder input.
- Target: bit-exact recovery of the encoder input stream under sparse channel bit errors.

Parameters:
- TB_DEPTH, 16: survivor path length in bits; decoder latency in decoder steps. Legal range 4..64.
- PM_W, 8: path-metric width in bits. Minimum 6.

Ports:
- clk  in  1  rising-edge clock for the whole block
- rst  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high
- enc_enable_i  in  1  encoder accepts enc_d_i this cycle
- enc_d_i  in  1  information bit
- enc_valid_o  out  1  enc_d_o holds a new symbol (one-cycle pulse per accepted bit)
- enc_d_o  out  2  coded symbol {g0,g1}
- dec_enable_i  in  1  decoder consumes dec_d_i this cycle
- dec_d_i  in  2  received hard-decision symbol {r0,r1}
- dec_valid_o  out  1  dec_d_o holds a decoded bit
- dec_d_o  out  1  decoded information bit

Behaviour:
- Trellis state s = {b1,b0} = {d(n-1), d(n-2)}. Input u moves the state to {u,b1}.
- Generators: g0 = u^b1^b0 (octal 7); g1 = u^b0 (octal 5).

Encoder:
- Reset: state=00, enc_d_o=00, enc_valid_o=0.
- Cycle with enc_enable_i=1 (registered outputs):
  - enc_d_o <= {u^b1^b0, u^b0} with u=enc_d_i
  - state <= {u,b1}
  - enc_valid_o <= 1
- Cycle with enc_enable_i=0: enc_valid_o <= 0; state and enc_d_o hold.
- Latency 1 cycle. Back-to-back enables give one symbol per cycle.

Decoder reset:
- PM[0]=0; PM[1..3]=16.
- All survivors 0; step counter 0; dec_valid_o=0; dec_d_o=0.

Decoder step (each cycle with dec_enable_i=1):
- Branch metric = Hamming distance (0..2) between dec_d_i and the expected {g0,g1} of each transition.
- Next state ns={u,p} has predecessors {p,0} and {p,1}. Candidate metric = PM[pred] + BM.
- Select the smaller candidate. On a tie, select predecessor {p,0}.
- Survivor update: SURV[ns] <= {SURV[pred][TB_DEPTH-2:0], u}. Newest bit is at bit 0.
- Normalization: if the minimum of the four new metrics is >= 2^(PM_W-2), subtract 2^(PM_W-2) from all four. Metrics must never wrap.
- best = state with minimum new metric; on a tie, the lowest index.
- dec_d_o <= new SURV[best][TB_DEPTH-1].
- Step counter increments, saturating at TB_DEPTH.
- dec_valid_o <= 1 iff the new counter value >= TB_DEPTH; otherwise 0.

Decoder idle (dec_enable_i=0):
- All state holds.
- dec_valid_o <= 0; dec_d_o holds.

Latency:
- The k-th consumed symbol (k from 0) yields the decoded bit for the (k-TB_DEPTH+1)-th information bit.
- That bit is registered in the cycle after the step.
- The first valid output follows the TB_DEPTH-th enabled step.

Boundaries:
- rst asserted mid-stream clears both halves on that edge; any partially decoded data is discarded.
- Gaps in enables are transparent: decode results are identical to those of a gap-free stream.
- rst has priority over the enables.

Test Plan:
- Reset, then encoder input 1,0,1,1,0,0 with enable every cycle -> enc_d_o = 11,10,00,01,01,11, each one cycle after its input; enc_valid_o high six cycles.
- Enable low for 3 cycles between bits -> enc_valid_o pulses only after enabled cycles; enc_d_o and state hold; output sequence matches the gap-free case.
- Loopback (enc_d_o registered once into dec_d_i, enc_valid_o delayed one cycle into dec_enable_i) with 256 random bits, no errors -> dec_valid_o rises after the 16th decoder step; dec_d_o equals the input delayed by 15 steps for all valid outputs.
- Same loopback with bit 1 of one symbol in every 16 inverted -> decoded stream still error-free. Check PM spread stays <= 4 and normalization fires without corrupting the output.
- All-zero input for 300 symbols -> PM[0] stays 0; no normalization; dec_d_o=0.
- Assert rst for one cycle after 40 loopback symbols -> next cycle: dec_valid_o=0, enc_d_o=00, PMs = 0/16/16/16. Decoding restarts with a fresh 16-step latency.

Source files
------------

// File: rtl/viterbi_codec_if.sv
// Encoder and decoder streaming signals of viterbi_codec, grouped as one bundle.
// The slave modport is the codec itself; the master modport is its environment.
interface viterbi_codec_if;
  logic       enc_enable_i;
  logic       enc_d_i;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i;
  logic [1:0] dec_d_i;
  logic       dec_valid_o;
  logic       dec_d_o;

  modport slave (
    input  enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
    output enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
  );

  modport master (
    output enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
    input  enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
  );
endinterface

// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 convolutional encoder (generators 7,5 octal) and a hard-decision
// Viterbi decoder with register-exchange survivors; the halves share only clk/rst.
module viterbi_codec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  viterbi_codec_if.slave bus
);
  localparam int              CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_NORM = PM_W'(1) << (PM_W - 2);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(16);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);

  logic [1:0] enc_state_q, enc_state_d;
  logic [1:0] enc_sym_q, enc_sym_d;
  logic       enc_valid_q, enc_valid_d;

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
    enc_state_d = enc_state_q;
    enc_sym_d   = enc_sym_q;
    enc_valid_d = bus.enc_enable_i;
    if (bus.enc_enable_i) begin
      enc_sym_d   = {bus.enc_d_i ^ enc_state_q[1] ^ enc_state_q[0], bus.enc_d_i ^ enc_state_q[0]};
      enc_state_d = {bus.enc_d_i, enc_state_q[1]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      enc_state_q <= '0;
      enc_sym_q   <= '0;
      enc_valid_q <= 1'b0;
    end else begin
      enc_state_q <= enc_state_d;
      enc_sym_q   <= enc_sym_d;
      enc_valid_q <= enc_valid_d;
    end
  end

  function automatic logic [1:0] bm_f(input logic [1:0] r, input logic g0, input logic g1);
    return 2'(r[1] ^ g0) + 2'(r[0] ^ g1);
  endfunction

  logic [PM_W-1:0]     pm_q [4];
  logic [PM_W-1:0]     pm_d [4];
  logic [PM_W-1:0]     cand0 [4];
  logic [PM_W-1:0]     cand1 [4];
  logic [PM_W-1:0]     pm_raw [4];
  logic                sel [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [TB_DEPTH-1:0] surv_new [4];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PM_W-1:0]     pm_min;
  logic [1:0]          best;
  logic                norm;
  logic                dec_valid_q, dec_valid_d;
  logic                dec_bit_q, dec_bit_d;

  always_comb begin
    // Next state ns={u,p}: predecessor {p,0} emits {u^p, u}, predecessor {p,1} the complement.
    for (int ns = 0; ns < 4; ns++) begin
      cand0[ns]    = pm_q[{ns[0], 1'b0}] + PM_W'(bm_f(bus.dec_d_i, ns[1] ^ ns[0], ns[1]));
      cand1[ns]    = pm_q[{ns[0], 1'b1}] + PM_W'(bm_f(bus.dec_d_i, ~(ns[1] ^ ns[0]), ~ns[1]));
      sel[ns]      = cand1[ns] < cand0[ns];
      pm_raw[ns]   = sel[ns] ? cand1[ns] : cand0[ns];
      surv_new[ns] = sel[ns] ? {surv_q[{ns[0], 1'b1}][TB_DEPTH-2:0], ns[1]}
                             : {surv_q[{ns[0], 1'b0}][TB_DEPTH-2:0], ns[1]};
    end

    pm_min = pm_raw[0];
    best   = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (pm_raw[s] < pm_min) begin
        pm_min = pm_raw[s];
        best   = 2'(s);
      end
    end
    norm = pm_min >= PM_NORM;

    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = 1'b0;
    if (bus.dec_enable_i) begin
      for (int s = 0; s < 4; s++) pm_d[s] = norm ? pm_raw[s] - PM_NORM : pm_raw[s];
      surv_d      = surv_new;
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      dec_bit_d   = surv_new[best][TB_DEPTH-1];
      dec_valid_d = cnt_d >= CNT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: survivors are reset like any other state because a restart must trace back through all-zero paths, not stale data.
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
      cnt_q       <= '0;
      dec_valid_q <= 1'b0;
      dec_bit_q   <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= dec_valid_d;
      dec_bit_q   <= dec_bit_d;
    end
  end

  assign bus.enc_valid_o = enc_valid_q;
  assign bus.enc_d_o     = enc_sym_q;
  assign bus.dec_valid_o = dec_valid_q;
  assign bus.dec_d_o     = dec_bit_q;
endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vectors, then encoder-to-decoder
// loopback with gaps, sparse errors, all-zero input and a mid-stream reset.
module tb_viterbi_codec;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_codec_if bus ();
  viterbi_codec #(.TB_DEPTH(16), .PM_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Loopback: encoder symbol registered once into the decoder, optional error on bit 1.
  logic [1:0] lb_d;
  logic       lb_v;
  logic       err_on;
  int         sym_cnt;
  int         steps;
  logic       inj;
  assign inj = err_on && ((sym_cnt % 16) == 7);

  always @(posedge clk) begin
    if (rst) begin
      lb_d    <= '0;
      lb_v    <= 1'b0;
      sym_cnt <= 0;
      steps   <= 0;
    end else begin
      lb_v <= bus.enc_valid_o;
      lb_d <= bus.enc_d_o ^ {inj & bus.enc_valid_o, 1'b0};
      if (bus.enc_valid_o) sym_cnt <= sym_cnt + 1;
      if (lb_v) steps <= steps + 1;
    end
  end

  assign bus.dec_enable_i = lb_v;
  assign bus.dec_d_i      = lb_d;

  int   sent_q[$];
  int   out_idx;
  bit   seen_valid;
  int   max_spread;
  int   norm_cnt;
  int   prev_min;

  always @(negedge clk) begin
    int mn, mx;
    if (rst) begin
      out_idx    = 0;
      seen_valid = 0;
      max_spread = 0;
      norm_cnt   = 0;
      prev_min   = 0;
    end else begin
      if (bus.dec_valid_o) begin
        if (!seen_valid) begin
          chk("first_valid_step", steps, 16);
          seen_valid = 1;
        end
        chk($sformatf("dec_bit%0d", out_idx), bus.dec_d_o,
            (out_idx < sent_q.size()) ? sent_q[out_idx] : 32'hFFFF_FFFF);
        out_idx++;
      end
      mn = int'(dut.pm_q[0]);
      mx = mn;
      for (int i = 1; i < 4; i++) begin
        if (int'(dut.pm_q[i]) < mn) mn = int'(dut.pm_q[i]);
        if (int'(dut.pm_q[i]) > mx) mx = int'(dut.pm_q[i]);
      end
      if (steps >= 2 && (mx - mn) > max_spread) max_spread = mx - mn;
      if (mn < prev_min) norm_cnt++;
      prev_min = mn;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.enc_enable_i = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sent_q.delete();
  endtask

  task automatic send(input logic b);
    bus.enc_enable_i = 1'b1;
    bus.enc_d_i      = b;
    sent_q.push_back(int'(b));
    @(posedge clk);
    #1;
    bus.enc_enable_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.enc_enable_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_enc_d"}, bus.enc_d_o, 0);
    chk({pfx, "_enc_valid"}, bus.enc_valid_o, 0);
    chk({pfx, "_dec_valid"}, bus.dec_valid_o, 0);
    chk({pfx, "_dec_d"}, bus.dec_d_o, 0);
    chk({pfx, "_pm0"}, dut.pm_q[0], 0);
    chk({pfx, "_pm1"}, dut.pm_q[1], 16);
    chk({pfx, "_pm2"}, dut.pm_q[2], 16);
    chk({pfx, "_pm3"}, dut.pm_q[3], 16);
  endtask

  task automatic run_lb(input string tag, input int n, input bit gaps, input bit zeros);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(zeros ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    idle(4);
    chk({tag, "_out_cnt"}, out_idx, n - 15);
  endtask

  logic       enc_bits [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] enc_syms [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    err_on           = 1'b0;
    bus.enc_enable_i = 1'b0;
    bus.enc_d_i      = 1'b0;
    do_reset();
    chk_reset_state("rst0");

    for (int i = 0; i < 6; i++) begin
      send(enc_bits[i]);
      chk($sformatf("enc_sym%0d", i), bus.enc_d_o, enc_syms[i]);
      chk($sformatf("enc_valid%0d", i), bus.enc_valid_o, 1);
    end
    idle(1);
    chk("enc_idle_valid", bus.enc_valid_o, 0);
    chk("enc_idle_hold", bus.enc_d_o, 2'b11);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(enc_bits[i]);
      chk($sformatf("gap_sym%0d", i), bus.enc_d_o, enc_syms[i]);
      chk($sformatf("gap_valid%0d", i), bus.enc_valid_o, 1);
      for (int g = 0; g < 3; g++) begin
        idle(1);
        chk($sformatf("gap_idle_valid%0d_%0d", i, g), bus.enc_valid_o, 0);
        chk($sformatf("gap_idle_hold%0d_%0d", i, g), bus.enc_d_o, enc_syms[i]);
      end
    end

    do_reset();
    run_lb("lb_clean", 256, 1'b0, 1'b0);

    do_reset();
    run_lb("lb_gaps", 200, 1'b1, 1'b0);

    do_reset();
    err_on = 1'b1;
    run_lb("lb_err", 1500, 1'b0, 1'b0);
    err_on = 1'b0;
    chk("err_pm_spread_le4", int'(max_spread <= 4), 1);
    chk("err_norm_fired", int'(norm_cnt > 0), 1);

    do_reset();
    run_lb("lb_zero", 300, 1'b0, 1'b1);
    chk("zero_pm0", dut.pm_q[0], 0);
    chk("zero_no_norm", norm_cnt, 0);

    do_reset();
    for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)));
    do_reset();
    chk_reset_state("rst_mid");
    run_lb("lb_restart", 64, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
